// File: rtl/bcd_pkg.sv
// Shared types and constants for the decimal-to-binary reassembler.
// Exports digit width/limit, the FSM state type and the digit-counter width helper.
package bcd_pkg;

   localparam int         DIGIT_W   = 4;
   localparam logic [3:0] DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_t;

   // The counter must be able to hold N_DIGITS itself, not just N_DIGITS-1.
   function automatic int cnt_w(input int n_digits);
      return $clog2(n_digits + 1);
   endfunction

endpackage

// File: rtl/bcd_to_bin_accum_if.sv
// Digit-in / result-out valid-ready bundle; master drives digits and accepts results.
// The slave modport is the reassembler side.
interface bcd_to_bin_accum_if
   import bcd_pkg::*;
#(
   parameter int W_OUT = 7
);
   logic               in_valid;
   logic               in_ready;
   logic [DIGIT_W-1:0] digit;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [W_OUT-1:0]   value;
   logic               err;

   modport master (
      output in_valid, digit, in_last, out_ready,
      input  in_ready, out_valid, value, err
   );

   modport slave (
      input  in_valid, digit, in_last, out_ready,
      output in_ready, out_valid, value, err
   );
endinterface

// File: rtl/bcd_mac10.sv
// Combinational acc*10+digit step with digit check; overflow either wraps or,
// with BCD_TO_BIN_ACCUM_SAT_EN defined, saturates to all-ones.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int W_OUT = 7
) (
   input  logic [W_OUT-1:0]   acc,
   input  logic [DIGIT_W-1:0] digit,
   output logic [W_OUT-1:0]   next,
   output logic               ovf,
   output logic               bad_digit
);
   localparam int               WW    = W_OUT + 4;
   localparam logic [WW-1:0]    MAX_W = {4'b0000, {W_OUT{1'b1}}};

   logic [WW-1:0] acc_w;
   logic [WW-1:0] dig_w;
   logic [WW-1:0] sum_w;

   // Four guard bits cover 10*(2^W_OUT-1)+9 without loss.
   always_comb begin
      bad_digit = (digit > DIGIT_MAX);
      acc_w     = {4'b0000, acc};
      dig_w     = bad_digit ? '0 : {{W_OUT{1'b0}}, digit};
      sum_w     = (acc_w << 3) + (acc_w << 1) + dig_w;
      ovf       = (sum_w > MAX_W);
`ifdef BCD_TO_BIN_ACCUM_SAT_EN
      next      = ovf ? {W_OUT{1'b1}} : sum_w[W_OUT-1:0];
`else
      next      = sum_w[W_OUT-1:0];
`endif
   end
endmodule

// File: rtl/bcd_to_bin_accum.sv
// Reassembles MSD-first decimal digits into a binary word; result valid 1 cycle after final digit.
// No input/output overlap: in_ready is low while a result waits; BCD_TO_BIN_ACCUM_SAT_EN selects saturation.
module bcd_to_bin_accum
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 2,
   parameter int W_OUT    = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_to_bin_accum_if.slave bus
);
   localparam int CNT_W = cnt_w(N_DIGITS);

   state_t           state_q, state_d;
   logic [W_OUT-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;
   logic [W_OUT-1:0] value_q, value_d;

   logic [W_OUT-1:0] mac_next;
   logic             mac_ovf;
   logic             mac_bad;
   logic             accept;
   logic             final_dig;
   logic [CNT_W-1:0] count_inc;

   bcd_mac10 #(.W_OUT(W_OUT)) u_mac (
      .acc       (acc_q),
      .digit     (bus.digit),
      .next      (mac_next),
      .ovf       (mac_ovf),
      .bad_digit (mac_bad)
   );

   assign bus.in_ready  = rst_n & (state_q != OUT);
   assign bus.out_valid = (state_q == OUT);
   assign bus.value     = value_q;
   assign bus.err       = err_q;

   assign accept    = bus.in_valid & bus.in_ready;
   assign count_inc = count_q + 1'b1;
   // in_last and the digit limit coinciding still yield one termination.
   assign final_dig = bus.in_last | (count_inc == CNT_W'(N_DIGITS));

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      err_d   = err_q;
      value_d = value_q;
      case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               acc_d   = mac_next;
               count_d = count_inc;
               err_d   = err_q | mac_ovf | mac_bad;
               if (final_dig) begin
                  state_d = OUT;
                  value_d = mac_next;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         err_q   <= err_d;
         value_q <= value_d;
      end
   end
endmodule

// File: tb/tb_bcd_to_bin_accum.sv
// Scoreboard bench: stimulus pushes expected results, per-instance monitors pop on output handshakes.
// A second instance with W_OUT=5 exercises the overflow path.
module tb_bcd_to_bin_accum;

   typedef struct packed {
      logic [6:0] v;
      logic       e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bcd_to_bin_accum_if #(.W_OUT(7)) bus ();
   bcd_to_bin_accum_if #(.W_OUT(5)) bus5 ();

   bcd_to_bin_accum #(.N_DIGITS(2), .W_OUT(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   bcd_to_bin_accum #(.N_DIGITS(2), .W_OUT(5)) dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus5.slave)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t q5[$];
   exp_t e_m;
   exp_t e_m5;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            flag("unexpected_result");
         end else begin
            e_m = q.pop_front();
            chk("value", {25'd0, bus.value}, {25'd0, e_m.v});
            chk("err", {31'd0, bus.err}, {31'd0, e_m.e});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus5.out_valid && bus5.out_ready) begin
         if (q5.size() == 0) begin
            flag("unexpected_result_w5");
         end else begin
            e_m5 = q5.pop_front();
            chk("value_w5", {27'd0, bus5.value}, {25'd0, e_m5.v});
            chk("err_w5", {31'd0, bus5.err}, {31'd0, e_m5.e});
         end
      end
   end

   task automatic send(input logic [3:0] d, input logic l);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.digit    = d;
      bus.in_last  = l;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) flag("accept_timeout");
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || q5.size() != 0) && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) flag("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.digit      = '0;
      bus.in_last    = 1'b0;
      bus.out_ready  = 1'b1;
      bus5.in_valid  = 1'b0;
      bus5.digit     = '0;
      bus5.in_last   = 1'b0;
      bus5.out_ready = 1'b1;

      #3;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_value", {25'd0, bus.value}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      #20;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 3,1(last): result registered one cycle after the last accept
      q.push_back('{v: 7'd31, e: 1'b0});
      send(4'd3, 1'b0);
      send(4'd1, 1'b1);
      @(negedge clk);
      chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd0);

      // single digit word, then auto-termination at N_DIGITS
      q.push_back('{v: 7'd7, e: 1'b0});
      send(4'd7, 1'b1);
      q.push_back('{v: 7'd12, e: 1'b0});
      send(4'd1, 1'b0);
      send(4'd2, 1'b0);

      // 99 fits in 7 bits, overflows 5 bits
      q.push_back('{v: 7'd99, e: 1'b0});
      send(4'd9, 1'b0);
      send(4'd9, 1'b1);
`ifdef BCD_TO_BIN_ACCUM_SAT_EN
      q5.push_back('{v: 7'd31, e: 1'b1});
`else
      q5.push_back('{v: 7'd3, e: 1'b1});
`endif
      bus5.in_valid = 1'b1;
      bus5.digit    = 4'd9;
      bus5.in_last  = 1'b0;
      @(negedge clk);
      chk("t3_w5_in_ready", {31'd0, bus5.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus5.in_last = 1'b1;
      @(negedge clk);
      chk("t3_w5_in_ready2", {31'd0, bus5.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus5.in_valid = 1'b0;
      bus5.in_last  = 1'b0;

      // invalid digit flags err; next word starts clean
      q.push_back('{v: 7'd5, e: 1'b1});
      send(4'hA, 1'b0);
      send(4'd5, 1'b1);
      q.push_back('{v: 7'd42, e: 1'b0});
      send(4'd4, 1'b0);
      send(4'd2, 1'b1);
      drain();

      // backpressure with a held digit waiting
      bus.out_ready = 1'b0;
      q.push_back('{v: 7'd64, e: 1'b0});
      send(4'd6, 1'b0);
      send(4'd4, 1'b1);
      bus.in_valid = 1'b1;
      bus.digit    = 4'd3;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("t5_value", {25'd0, bus.value}, 32'd64);
         chk("t5_err", {31'd0, bus.err}, 32'd0);
         chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      q.push_back('{v: 7'd3, e: 1'b0});
      bus.out_ready = 1'b1;
      send(4'd3, 1'b1);
      drain();

      // reset mid-word discards the partial value
      send(4'd2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t6_value", {25'd0, bus.value}, 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      q.push_back('{v: 7'd45, e: 1'b0});
      send(4'd4, 1'b0);
      send(4'd5, 1'b1);
      drain();
      @(negedge clk);
      chk("t6_value_held", {25'd0, bus.value}, 32'd45);
      chk("t6_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("q_empty", q.size(), 32'd0);
      chk("q5_empty", q5.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
